// File: rtl/reg_write_buffer.sv
// In-order writeback buffer in front of the register file write port.
// Pending entries are visible to two read lookups; the newest matching entry wins.
module reg_write_buffer #(
    parameter int N     = 72,
    parameter int A     = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [A-1:0]               wb_addr,
    input  logic [N-1:0]               wb_data,
    output logic                       rf_wr_en,
    input  logic                       rf_wr_ready,
    output logic [A-1:0]               rf_wr_addr,
    output logic [N-1:0]               rf_wr_data,
    input  logic [A-1:0]               lk_addr1,
    input  logic [A-1:0]               lk_addr2,
    output logic                       lk_hit1,
    output logic                       lk_hit2,
    output logic [N-1:0]               lk_data1,
    output logic [N-1:0]               lk_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A-1:0]  addrQ [DEPTH];
    logic [N-1:0]  dataQ [DEPTH];
    logic [PW-1:0] wrPtrQ, wrPtrD;
    logic [PW-1:0] rdPtrQ, rdPtrD;
    logic [CW-1:0] countQ, countD;

    logic full, empty, pushEn, popEn;

    // A full cycle never accepts a push, even if the head retires in that cycle.
    assign full   = (countQ == CW'(DEPTH));
    assign empty  = (countQ == '0);
    assign pushEn = wb_valid && !full;
    assign popEn  = !empty && rf_wr_ready;

    assign wb_ready   = !full;
    assign rf_wr_en   = !empty;
    assign rf_wr_addr = addrQ[rdPtrQ];
    assign rf_wr_data = dataQ[rdPtrQ];
    assign count      = countQ;

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (pushEn) begin
            wrPtrD = wrPtrQ + 1'b1;
        end
        if (popEn) begin
            rdPtrD = rdPtrQ + 1'b1;
        end
        case ({pushEn, popEn})
            2'b10:   countD = countQ + 1'b1;
            2'b01:   countD = countQ - 1'b1;
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    // Storage needs no reset: only slots covered by the count are ever observed.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            addrQ[wrPtrQ] <= wb_addr;
            dataQ[wrPtrQ] <= wb_data;
        end
    end

    // Walk from oldest to newest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] slot;
        slot     = '0;
        lk_hit1  = 1'b0;
        lk_hit2  = 1'b0;
        lk_data1 = '0;
        lk_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rdPtrQ + PW'(i);
            if (CW'(i) < countQ) begin
                if (addrQ[slot] == lk_addr1) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = dataQ[slot];
                end
                if (addrQ[slot] == lk_addr2) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = dataQ[slot];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: queue-based scoreboard on every cycle
// plus a table of lookup/count vectors for the bypass corner cases.
module tb_reg_write_buffer;

    localparam int N     = 72;
    localparam int A     = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic          wb_ready;
    logic [A-1:0]  wb_addr;
    logic [N-1:0]  wb_data;
    logic          rf_wr_en;
    logic          rf_wr_ready;
    logic [A-1:0]  rf_wr_addr;
    logic [N-1:0]  rf_wr_data;
    logic [A-1:0]  lk_addr1;
    logic [A-1:0]  lk_addr2;
    logic          lk_hit1;
    logic          lk_hit2;
    logic [N-1:0]  lk_data1;
    logic [N-1:0]  lk_data2;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    reg_write_buffer #(.N(N), .A(A), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_ready (rf_wr_ready),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .lk_addr1    (lk_addr1),
        .lk_addr2    (lk_addr2),
        .lk_hit1     (lk_hit1),
        .lk_hit2     (lk_hit2),
        .lk_data1    (lk_data1),
        .lk_data2    (lk_data2),
        .count       (count)
    );

    typedef struct {
        logic [A-1:0] addr;
        logic [N-1:0] data;
    } entry_t;

    typedef struct {
        logic         valid;
        logic [A-1:0] addr;
        logic [N-1:0] data;
        logic         rdy;
        logic [A-1:0] lk1;
        logic [A-1:0] lk2;
        logic         expHit1;
        logic [N-1:0] expData1;
        logic         expHit2;
        logic [N-1:0] expData2;
        int           expCount;
    } vector_t;

    entry_t  sbQ[$];
    vector_t vecs[16];
    int      checks = 0;
    int      errors = 0;

    // Every comparison in the bench funnels through here so the counters stay honest.
    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void modelLookup(input logic [A-1:0] a, output logic hit, output logic [N-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (sbQ[i]) begin
            if (sbQ[i].addr == a) begin
                hit = 1'b1;
                d   = sbQ[i].data;
            end
        end
    endfunction

    // Drive one cycle at the falling edge, score the settled outputs, then advance the model.
    task automatic applyStimulus(input logic v, input logic [A-1:0] a, input logic [N-1:0] d,
                                 input logic rdy, input logic [A-1:0] l1, input logic [A-1:0] l2);
        logic         h;
        logic [N-1:0] md;
        int           preSize;
        @(negedge clk);
        wb_valid    = v;
        wb_addr     = a;
        wb_data     = d;
        rf_wr_ready = rdy;
        lk_addr1    = l1;
        lk_addr2    = l2;
        #1;
        preSize = sbQ.size();
        check("sb_count", N'(count), N'(preSize));
        check("sb_wb_ready", N'(wb_ready), N'(preSize < DEPTH));
        check("sb_rf_wr_en", N'(rf_wr_en), N'(preSize > 0));
        if (preSize > 0) begin
            check("sb_head_addr", N'(rf_wr_addr), N'(sbQ[0].addr));
            check("sb_head_data", rf_wr_data, sbQ[0].data);
        end
        modelLookup(l1, h, md);
        check("sb_lk_hit1", N'(lk_hit1), N'(h));
        check("sb_lk_data1", lk_data1, md);
        modelLookup(l2, h, md);
        check("sb_lk_hit2", N'(lk_hit2), N'(h));
        check("sb_lk_data2", lk_data2, md);
        if (preSize > 0 && rdy) begin
            void'(sbQ.pop_front());
        end
        if (v && preSize < DEPTH) begin
            sbQ.push_back('{addr: a, data: d});
        end
    endtask

    task automatic checkOutput(input int idx);
        vector_t t;
        t = vecs[idx];
        check($sformatf("vec%0d_hit1", idx), N'(lk_hit1), N'(t.expHit1));
        check($sformatf("vec%0d_data1", idx), lk_data1, t.expData1);
        check($sformatf("vec%0d_hit2", idx), N'(lk_hit2), N'(t.expHit2));
        check($sformatf("vec%0d_data2", idx), lk_data2, t.expData2);
        check($sformatf("vec%0d_count", idx), N'(count), N'(t.expCount));
    endtask

    initial begin
        // Bypass newest-wins with a drain, then pop/push of the same address in one cycle.
        vecs[0]  = '{1'b1, 6'd7, 72'hAA, 1'b0, 6'd7, 6'd9, 1'b0, 72'h0,  1'b0, 72'h0,  0};
        vecs[1]  = '{1'b1, 6'd9, 72'hBB, 1'b0, 6'd7, 6'd9, 1'b1, 72'hAA, 1'b0, 72'h0,  1};
        vecs[2]  = '{1'b1, 6'd7, 72'hCC, 1'b0, 6'd7, 6'd9, 1'b1, 72'hAA, 1'b1, 72'hBB, 2};
        vecs[3]  = '{1'b0, 6'd0, 72'h0,  1'b0, 6'd7, 6'd9, 1'b1, 72'hCC, 1'b1, 72'hBB, 3};
        vecs[4]  = '{1'b0, 6'd0, 72'h0,  1'b0, 6'd3, 6'd9, 1'b0, 72'h0,  1'b1, 72'hBB, 3};
        vecs[5]  = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd7, 6'd9, 1'b1, 72'hCC, 1'b1, 72'hBB, 3};
        vecs[6]  = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd7, 6'd9, 1'b1, 72'hCC, 1'b1, 72'hBB, 2};
        vecs[7]  = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd7, 6'd9, 1'b1, 72'hCC, 1'b0, 72'h0,  1};
        vecs[8]  = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd7, 6'd9, 1'b0, 72'h0,  1'b0, 72'h0,  0};
        vecs[9]  = '{1'b1, 6'd5, 72'h55, 1'b0, 6'd5, 6'd6, 1'b0, 72'h0,  1'b0, 72'h0,  0};
        vecs[10] = '{1'b1, 6'd6, 72'h66, 1'b0, 6'd5, 6'd6, 1'b1, 72'h55, 1'b0, 72'h0,  1};
        vecs[11] = '{1'b1, 6'd5, 72'h77, 1'b1, 6'd5, 6'd6, 1'b1, 72'h55, 1'b1, 72'h66, 2};
        vecs[12] = '{1'b0, 6'd0, 72'h0,  1'b0, 6'd5, 6'd6, 1'b1, 72'h77, 1'b1, 72'h66, 2};
        vecs[13] = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd5, 6'd6, 1'b1, 72'h77, 1'b1, 72'h66, 2};
        vecs[14] = '{1'b0, 6'd0, 72'h0,  1'b1, 6'd5, 6'd6, 1'b1, 72'h77, 1'b0, 72'h0,  1};
        vecs[15] = '{1'b0, 6'd0, 72'h0,  1'b0, 6'd5, 6'd6, 1'b0, 72'h0,  1'b0, 72'h0,  0};

        reset       = 1'b0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        rf_wr_ready = 1'b0;
        lk_addr1    = '0;
        lk_addr2    = '0;
        #2;
        check("rst_wb_ready", N'(wb_ready), N'(1));
        check("rst_rf_wr_en", N'(rf_wr_en), N'(0));
        check("rst_count", N'(count), N'(0));
        check("rst_lk_hit1", N'(lk_hit1), N'(0));
        check("rst_lk_hit2", N'(lk_hit2), N'(0));
        check("rst_lk_data1", lk_data1, '0);
        check("rst_lk_data2", lk_data2, '0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].rdy, vecs[i].lk1, vecs[i].lk2);
            checkOutput(i);
        end

        $display("[TB] fill and backpressure");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 6'(i), 72'(i * 16'h1111), 1'b0, 6'd4, 6'd5);
        end
        applyStimulus(1'b1, 6'd5, 72'h5555, 1'b0, 6'd4, 6'd5);
        check("full_wb_ready", N'(wb_ready), N'(0));
        applyStimulus(1'b1, 6'd5, 72'h5555, 1'b0, 6'd4, 6'd5);
        check("full_count_held", N'(count), N'(4));
        applyStimulus(1'b1, 6'd5, 72'h5555, 1'b1, 6'd4, 6'd5);
        check("full_pop_no_push", N'(wb_ready), N'(0));
        applyStimulus(1'b1, 6'd5, 72'h5555, 1'b1, 6'd4, 6'd5);
        check("refill_accept", N'(wb_ready), N'(1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 6'd0, 72'h0, 1'b1, 6'd4, 6'd5);
        end
        check("fill_drained", N'(count), N'(0));

        $display("[TB] streaming wrap");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 6'(20 + i), 72'(256 + i), 1'b1, 6'(20 + i), 6'(19 + i));
        end
        applyStimulus(1'b0, 6'd0, 72'h0, 1'b1, 6'd29, 6'd0);
        applyStimulus(1'b0, 6'd0, 72'h0, 1'b1, 6'd29, 6'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'(40 + i), 72'(i + 72'hF00), 1'b0, 6'd40, 6'd42);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_count", N'(count), N'(0));
        check("async_rst_rf_wr_en", N'(rf_wr_en), N'(0));
        check("async_rst_wb_ready", N'(wb_ready), N'(1));
        check("async_rst_lk_hit1", N'(lk_hit1), N'(0));
        sbQ.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'd0, 72'h0, 1'b1, 6'd40, 6'd42);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
